// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   SHA-256 message schedule. Takes the 16 words of a 512-bit block serially,
//   forwards them as W0..W15, then forms W16..W63 by handing
//   sigma1(W[t-2]), W[t-7], sigma0(W[t-15]) and W[t-16] to an external
//   4-operand carry-save compressor and capturing its sum mod 2^32.
//   Every Wt leaves on a valid/ready stream tagged with its round index.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      begins a block when idle
//   w_in_valid/ready/data      message word input, M0 first
//   op_a..op_d, op_cin         compressor operands (op_cin is always zero)
//   cmp_sum                    compressor sum, only bits [31:0] are used
//   wt_valid/ready/data/idx    schedule word output stream
//   busy                       block in progress
//   done                       one-cycle pulse after W63 is accepted
//
// Build option
//   SCHED_OPREG_EN: registers op_a..op_d. Each expanded word then takes two
//   cycles (operand load, then sum capture). Message load timing is unchanged.
module sha256_msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_in_valid,
  input  logic [WORD_W-1:0] w_in_data,
  output logic              w_in_ready,
  output logic [WORD_W-1:0] op_a,
  output logic [WORD_W-1:0] op_b,
  output logic [WORD_W-1:0] op_c,
  output logic [WORD_W-1:0] op_d,
  output logic [WORD_W-1:0] op_cin,
  input  logic [WORD_W+1:0] cmp_sum,
  output logic              wt_valid,
  input  logic              wt_ready,
  output logic [WORD_W-1:0] wt_data,
  output logic [5:0]        wt_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

  localparam logic [5:0] LOAD_LAST = 6'd15;
  localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);

  state_t            state;
  logic [5:0]        t;
  logic [WORD_W-1:0] win [16];

  logic              slot_free;
  logic              load_acc;
  logic              exp_fire;
  logic              new_word;
  logic [WORD_W-1:0] new_data;
  logic              unused_sum_hi;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Carry-out bits of the compressor are dropped: every sum is mod 2^32.
  assign unused_sum_hi = ^cmp_sum[WORD_W+1:WORD_W];

  assign op_cin     = '0;
  assign slot_free  = !wt_valid || wt_ready;
  assign w_in_ready = (state == LOAD) && slot_free;
  assign busy       = (state != IDLE);
  assign load_acc   = (state == LOAD) && w_in_valid && slot_free;
  assign new_word   = load_acc || exp_fire;
  assign new_data   = (state == LOAD) ? w_in_data : cmp_sum[WORD_W-1:0];

`ifdef SCHED_OPREG_EN
  // op_phase=0: operands are loaded from the window this cycle;
  // op_phase=1: the compressor sum is captured once the output slot is free.
  // The window only moves on a capture, so the loaded operands stay current.
  logic op_phase;

  assign exp_fire = (state == EXPAND) && op_phase && slot_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_phase <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      op_d     <= '0;
    end else if (state == EXPAND) begin
      if (!op_phase) begin
        op_a     <= small_sigma1(win[14]);
        op_b     <= win[9];
        op_c     <= small_sigma0(win[1]);
        op_d     <= win[0];
        op_phase <= 1'b1;
      end else if (exp_fire) begin
        op_phase <= 1'b0;
      end
    end else begin
      op_phase <= 1'b0;
    end
  end
`else
  assign exp_fire = (state == EXPAND) && slot_free;
  assign op_a     = small_sigma1(win[14]);
  assign op_b     = win[9];
  assign op_c     = small_sigma0(win[1]);
  assign op_d     = win[0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      t        <= '0;
      wt_valid <= 1'b0;
      wt_data  <= '0;
      wt_idx   <= '0;
      done     <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      done <= 1'b0;

      if (new_word) begin
        wt_data  <= new_data;
        wt_idx   <= t;
        wt_valid <= 1'b1;
        for (int unsigned i = 0; i < 15; i++) begin
          win[i] <= win[i+1];
        end
        win[15] <= new_data;
        // t holds at the last round so the 6-bit counter never wraps.
        if (t != LAST_T) begin
          t <= t + 6'd1;
        end
      end else if (wt_valid && wt_ready) begin
        wt_valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            t     <= '0;
          end
        end
        LOAD: begin
          if (load_acc && (t == LOAD_LAST)) begin
            state <= EXPAND;
          end
        end
        EXPAND: begin
          if (exp_fire && (t == LAST_T)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wt_valid && wt_ready) begin
            state <= IDLE;
            done  <= 1'b1;
            t     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
